ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch_pkg.sv | 19 +
 rtl/ifu_fetch.sv | 170 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// RV32I constants used when presenting a faulted fetch to decode.
package ifu_fetch_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } ifu_state_t;

   // Canonical RV32I NOP (addi x0, x0, 0) substituted for faulted fetches
   localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

   // Size of one instruction in bytes, used for sequential pc advance
   localparam int unsigned INST_BYTES = 4;

endpackage : ifu_fetch_pkg

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the pc, issues one fetch at a time on the
// instruction bus and presents the result to decode under valid/ready.
// Redirects retarget the pc; any fetch already in flight is drained and
// dropped through the kill flag.
// Optional build macro IFU_MISALIGN_CHK_EN: a redirect to a non-word-aligned
// target skips the bus and hands decode a faulted NOP with ifu_misalign set.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int unsigned          XLEN     = 32,
   parameter logic [XLEN-1:0]      RESET_PC = XLEN'(32'h8000_0000)
) (
   input  logic            clk,
   input  logic            rst,
   // instruction bus request channel
   output logic            ibus_req_valid,
   input  logic            ibus_req_ready,
   output logic [XLEN-1:0] ibus_req_addr,
   // instruction bus response channel
   input  logic            ibus_rsp_valid,
   input  logic [XLEN-1:0] ibus_rsp_data,
   input  logic            ibus_rsp_err,
   // redirect from execute/commit
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   // decode interface
   output logic            ifu_valid,
   input  logic            ifu_ready,
   output logic [XLEN-1:0] ifu_inst,
   output logic [XLEN-1:0] ifu_pc,
   output logic            ifu_fault
`ifdef IFU_MISALIGN_CHK_EN
   ,
   output logic            ifu_misalign
`endif
);

   localparam logic [XLEN-1:0] INST_INC   = XLEN'(INST_BYTES);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] NOP_WORD   = XLEN'(RV32I_NOP);

   ifu_state_t      state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_addr;
   logic            req_valid;
   logic            kill;

   logic [XLEN-1:0] tgt_pc_c;
   logic            tgt_mis_c;
   logic            launch_c;

   // Target of the next fetch launch: redirect wins, otherwise sequential
   // advance out of OUT, otherwise the current pc
   always_comb begin
      tgt_pc_c = pc;
      if (redirect_valid) begin
         tgt_pc_c = redirect_pc;
      end else if (state == OUT) begin
         tgt_pc_c = pc + INST_INC;
      end
   end

`ifdef IFU_MISALIGN_CHK_EN
   logic mis_pend;

   // Launch target is misaligned if this cycle's redirect is, or an earlier
   // redirect was while an old fetch was still draining
   assign tgt_mis_c = redirect_valid ? (redirect_pc[1:0] != 2'b00) : mis_pend;
`else
   assign tgt_mis_c = 1'b0;
`endif

   // Cycles in which the FSM leaves for a new fetch (or a misalign fault)
   always_comb begin
      launch_c = 1'b0;
      unique case (state)
         IDLE: launch_c = 1'b1;
         REQ:  launch_c = 1'b0;
         WAIT: launch_c = ibus_rsp_valid & (kill | redirect_valid);
         OUT:  launch_c = redirect_valid | ifu_ready;
         default: launch_c = 1'b0;
      endcase
   end

   // Fetch FSM with pc, kill and the decode-side output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         kill      <= 1'b0;
         req_valid <= 1'b0;
         req_addr  <= RESET_PC & ALIGN_MASK;
         ifu_inst  <= '0;
         ifu_fault <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
         ifu_misalign <= 1'b0;
         mis_pend     <= 1'b0;
`endif
      end else begin
         // pc tracks the instruction being fetched/presented; redirect first
         if (redirect_valid) begin
            pc <= redirect_pc;
         end else if ((state == OUT) && ifu_ready) begin
            pc <= pc + INST_INC;
         end

`ifdef IFU_MISALIGN_CHK_EN
         if (redirect_valid) begin
            mis_pend <= (redirect_pc[1:0] != 2'b00);
         end
`endif

         unique case (state)
            IDLE: ;
            REQ: begin
               // address stays frozen until accepted; a redirect only kills
               if (ibus_req_ready) begin
                  state     <= WAIT;
                  req_valid <= 1'b0;
               end
               if (redirect_valid) begin
                  kill <= 1'b1;
               end
            end
            WAIT: begin
               if (ibus_rsp_valid) begin
                  if (kill || redirect_valid) begin
                     kill <= 1'b0;
                  end else begin
                     state     <= OUT;
                     ifu_inst  <= ibus_rsp_err ? NOP_WORD : ibus_rsp_data;
                     ifu_fault <= ibus_rsp_err;
`ifdef IFU_MISALIGN_CHK_EN
                     ifu_misalign <= 1'b0;
`endif
                  end
               end else if (redirect_valid) begin
                  kill <= 1'b1;
               end
            end
            OUT: ;
            default: state <= IDLE;
         endcase

         // Start the next fetch, or short-circuit a misaligned target to OUT
         if (launch_c) begin
            if (tgt_mis_c) begin
               state     <= OUT;
               ifu_inst  <= NOP_WORD;
               ifu_fault <= 1'b1;
`ifdef IFU_MISALIGN_CHK_EN
               ifu_misalign <= 1'b1;
               mis_pend     <= 1'b0;
`endif
            end else begin
               state     <= REQ;
               req_valid <= 1'b1;
               req_addr  <= tgt_pc_c & ALIGN_MASK;
            end
         end
      end
   end

   // Decode sees nothing in a redirect cycle so a wrong-path word never retires
   assign ifu_valid      = (state == OUT) & ~redirect_valid;
   assign ifu_pc         = pc;
   assign ibus_req_valid = req_valid;
   assign ibus_req_addr  = req_addr;

endmodule : ifu_fetch

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a one-cycle-latency bus model, a
// scoreboard of expected decode handshakes, and one task per scenario.
module tb_ifu_fetch;
   import ifu_fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic        ibus_req_valid;
   logic        ibus_req_ready;
   logic [31:0] ibus_req_addr;
   logic        ibus_rsp_valid;
   logic [31:0] ibus_rsp_data;
   logic        ibus_rsp_err;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ifu_valid;
   logic        ifu_ready;
   logic [31:0] ifu_inst;
   logic [31:0] ifu_pc;
   logic        ifu_fault;
`ifdef IFU_MISALIGN_CHK_EN
   logic        ifu_misalign;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
      logic        mis;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        sb_e;
   int unsigned n_pass;
   int unsigned n_total;
   logic        have_acc;
   logic [31:0] acc_addr;
   logic [31:0] err_addr;

   ifu_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .ibus_req_valid (ibus_req_valid),
      .ibus_req_ready (ibus_req_ready),
      .ibus_req_addr  (ibus_req_addr),
      .ibus_rsp_valid (ibus_rsp_valid),
      .ibus_rsp_data  (ibus_rsp_data),
      .ibus_rsp_err   (ibus_rsp_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ifu_valid      (ifu_valid),
      .ifu_ready      (ifu_ready),
      .ifu_inst       (ifu_inst),
      .ifu_pc         (ifu_pc),
      .ifu_fault      (ifu_fault)
`ifdef IFU_MISALIGN_CHK_EN
      ,
      .ifu_misalign   (ifu_misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents seen by the bus model
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RST_PC) return 32'h0000_0093;
      return {a[31:2], 2'b00} ^ 32'h5A5A_0013;
   endfunction

   // Bus model: a request accepted at an edge is answered in the next cycle
   initial begin
      have_acc       = 1'b0;
      acc_addr       = '0;
      ibus_rsp_valid = 1'b0;
      ibus_rsp_data  = '0;
      ibus_rsp_err   = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (have_acc) begin
            ibus_rsp_valid = 1'b1;
            ibus_rsp_data  = mem_word(acc_addr);
            ibus_rsp_err   = (acc_addr == err_addr);
         end else begin
            ibus_rsp_valid = 1'b0;
            ibus_rsp_data  = '0;
            ibus_rsp_err   = 1'b0;
         end
         @(negedge clk);
         have_acc = ibus_req_valid && ibus_req_ready && !rst;
         acc_addr = ibus_req_addr;
      end
   end

   // Scoreboard: every decode handshake must match the oldest expectation
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && ifu_valid && ifu_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected handshake pc=%h inst=%h fault=%b", ifu_pc, ifu_inst, ifu_fault);
            end else begin
               sb_e = exp_q.pop_front();
               if (ifu_pc !== sb_e.pc || ifu_inst !== sb_e.inst || ifu_fault !== sb_e.fault
`ifdef IFU_MISALIGN_CHK_EN
                   || ifu_misalign !== sb_e.mis
`endif
                  ) begin
                  $display("FAIL sb_handshake got pc=%h inst=%h fault=%b exp pc=%h inst=%h fault=%b",
                           ifu_pc, ifu_inst, ifu_fault, sb_e.pc, sb_e.inst, sb_e.fault);
               end else begin
                  n_pass++;
               end
            end
         end
      end
   end

   task automatic do_reset(input logic rq_rdy, input logic if_rdy);
      @(posedge clk); #1;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ibus_req_ready = rq_rdy;
      ifu_ready      = if_rdy;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_total++;
      if (ibus_req_valid !== 1'b0 || ifu_valid !== 1'b0 || ifu_fault !== 1'b0) begin
         $display("FAIL reset_ctrl got req_valid=%b ifu_valid=%b fault=%b exp 0 0 0", ibus_req_valid, ifu_valid, ifu_fault);
      end else n_pass++;
      n_total++;
      if (ifu_inst !== 32'h0 || ifu_pc !== RST_PC) begin
         $display("FAIL reset_regs got inst=%h pc=%h exp inst=00000000 pc=%h", ifu_inst, ifu_pc, RST_PC);
      end else n_pass++;
   endtask

   task automatic test_first_fetch();
      do_reset(1'b1, 1'b1);
      exp_q.push_back('{RST_PC, 32'h0000_0093, 1'b0, 1'b0});
      @(negedge clk);
      n_total++;
      if (ibus_req_valid !== 1'b0) $display("FAIL first_idle got req_valid=%b exp 0", ibus_req_valid);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (ibus_req_valid !== 1'b1 || ibus_req_addr !== RST_PC)
         $display("FAIL first_req got valid=%b addr=%h exp 1 %h", ibus_req_valid, ibus_req_addr, RST_PC);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (ifu_valid !== 1'b0) $display("FAIL first_wait got ifu_valid=%b exp 0", ifu_valid);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (ifu_valid !== 1'b1 || ifu_pc !== RST_PC)
         $display("FAIL first_out got valid=%b pc=%h exp 1 %h", ifu_valid, ifu_pc, RST_PC);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (ibus_req_valid !== 1'b1 || ibus_req_addr !== 32'h8000_0004)
         $display("FAIL first_next got valid=%b addr=%h exp 1 80000004", ibus_req_valid, ibus_req_addr);
      else n_pass++;
   endtask

   task automatic test_decode_stall();
      logic got;
      do_reset(1'b1, 1'b0);
      exp_q.push_back('{RST_PC, 32'h0000_0093, 1'b0, 1'b0});
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ifu_valid) begin got = 1'b1; break; end
      end
      n_total++;
      if (!got) $display("FAIL stall_timeout got no ifu_valid exp ifu_valid within 10 cycles");
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         n_total++;
         if (ifu_valid !== 1'b1 || ifu_inst !== 32'h0000_0093 || ifu_pc !== RST_PC || ibus_req_valid !== 1'b0)
            $display("FAIL stall_hold cyc=%0d got valid=%b inst=%h pc=%h req=%b exp 1 00000093 %h 0",
                     k, ifu_valid, ifu_inst, ifu_pc, ibus_req_valid, RST_PC);
         else n_pass++;
      end
      @(posedge clk); #1;
      ifu_ready = 1'b1;
      @(posedge clk); #1;
      ifu_ready = 1'b0;
      @(negedge clk);
      n_total++;
      if (ifu_pc !== 32'h8000_0004 || ibus_req_valid !== 1'b1 || ibus_req_addr !== 32'h8000_0004)
         $display("FAIL stall_advance got pc=%h req=%b addr=%h exp 80000004 1 80000004", ifu_pc, ibus_req_valid, ibus_req_addr);
      else n_pass++;
      n_total++;
      if (exp_q.size() != 0) $display("FAIL stall_drain got %0d pending exp 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_req_stall_redirect();
      logic seen_low;
      logic found;
      do_reset(1'b0, 1'b1);
      exp_q.push_back('{32'h8000_0100, mem_word(32'h8000_0100), 1'b0, 1'b0});
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         redirect_valid = (k == 1);
         redirect_pc    = 32'h8000_0100;
         @(negedge clk);
         n_total++;
         if (ibus_req_valid !== 1'b1 || ibus_req_addr !== RST_PC)
            $display("FAIL reqstall_hold cyc=%0d got valid=%b addr=%h exp 1 %h", k, ibus_req_valid, ibus_req_addr, RST_PC);
         else n_pass++;
      end
      n_total++;
      if (ifu_pc !== 32'h8000_0100) $display("FAIL reqstall_pc got %h exp 80000100", ifu_pc);
      else n_pass++;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      ibus_req_ready = 1'b1;
      seen_low = 1'b0;
      found    = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (!ibus_req_valid) seen_low = 1'b1;
         else if (seen_low) begin found = 1'b1; break; end
      end
      n_total++;
      if (!found || ibus_req_addr !== 32'h8000_0100)
         $display("FAIL reqstall_refetch got found=%b addr=%h exp 1 80000100", found, ibus_req_addr);
      else n_pass++;
      wait_drain();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL reqstall_drain got %0d pending exp 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_redirect_rsp();
      do_reset(1'b1, 1'b1);
      exp_q.push_back('{32'h8000_0200, mem_word(32'h8000_0200), 1'b0, 1'b0});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ibus_req_valid && ibus_req_ready) break;
      end
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      @(negedge clk);
      n_total++;
      if (ifu_valid !== 1'b0) $display("FAIL rsp_redirect_valid got %b exp 0", ifu_valid);
      else n_pass++;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (ifu_valid !== 1'b0 || ibus_req_valid !== 1'b1 || ibus_req_addr !== 32'h8000_0200)
         $display("FAIL rsp_redirect_refetch got ifu_valid=%b req=%b addr=%h exp 0 1 80000200", ifu_valid, ibus_req_valid, ibus_req_addr);
      else n_pass++;
      wait_drain();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL rsp_redirect_drain got %0d pending exp 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_redirect_out();
      do_reset(1'b1, 1'b1);
      exp_q.push_back('{32'h8000_0300, mem_word(32'h8000_0300), 1'b0, 1'b0});
      repeat (3) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0300;
      @(negedge clk);
      n_total++;
      if (ifu_valid !== 1'b0 || ifu_inst !== 32'h0000_0093)
         $display("FAIL out_redirect_mask got valid=%b inst=%h exp 0 00000093", ifu_valid, ifu_inst);
      else n_pass++;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (ibus_req_valid !== 1'b1 || ibus_req_addr !== 32'h8000_0300 || ifu_pc !== 32'h8000_0300)
         $display("FAIL out_redirect_refetch got req=%b addr=%h pc=%h exp 1 80000300 80000300", ibus_req_valid, ibus_req_addr, ifu_pc);
      else n_pass++;
      wait_drain();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL out_redirect_drain got %0d pending exp 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_fault();
      logic got;
      err_addr = RST_PC;
      do_reset(1'b1, 1'b1);
      exp_q.push_back('{RST_PC, RV32I_NOP, 1'b1, 1'b0});
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ifu_valid) begin got = 1'b1; break; end
      end
      n_total++;
      if (!got || ifu_fault !== 1'b1 || ifu_inst !== RV32I_NOP)
         $display("FAIL fault_out got valid=%b fault=%b inst=%h exp 1 1 00000013", got, ifu_fault, ifu_inst);
      else n_pass++;
      wait_drain();
      err_addr = 32'h0000_0001;
      n_total++;
      if (exp_q.size() != 0) $display("FAIL fault_drain got %0d pending exp 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset(1'b1, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      exp_q.push_back('{32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b0, 1'b0});
      exp_q.push_back('{32'h0000_0000, mem_word(32'h0000_0000), 1'b0, 1'b0});
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (ibus_req_valid !== 1'b1 || ibus_req_addr !== 32'hFFFF_FFFC)
         $display("FAIL wrap_req got req=%b addr=%h exp 1 fffffffc", ibus_req_valid, ibus_req_addr);
      else n_pass++;
      wait_drain();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL wrap_drain got %0d pending exp 0", exp_q.size());
      else n_pass++;
   endtask

`ifdef IFU_MISALIGN_CHK_EN
   task automatic test_misalign();
      do_reset(1'b1, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      exp_q.push_back('{32'h8000_0102, RV32I_NOP, 1'b1, 1'b1});
      exp_q.push_back('{32'h8000_0106, mem_word(32'h8000_0104), 1'b0, 1'b0});
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (ifu_valid !== 1'b1 || ibus_req_valid !== 1'b0 || ifu_misalign !== 1'b1 || ifu_pc !== 32'h8000_0102)
         $display("FAIL misalign_out got valid=%b req=%b mis=%b pc=%h exp 1 0 1 80000102",
                  ifu_valid, ibus_req_valid, ifu_misalign, ifu_pc);
      else n_pass++;
      wait_drain();
      n_total++;
      if (exp_q.size() != 0) $display("FAIL misalign_drain got %0d pending exp 0", exp_q.size());
      else n_pass++;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass         = 0;
      n_total        = 0;
      rst            = 1'b1;
      ibus_req_ready = 1'b1;
      ifu_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      err_addr       = 32'h0000_0001;
      test_reset();
      test_first_fetch();
      test_decode_stall();
      test_req_stall_redirect();
      test_redirect_rsp();
      test_redirect_out();
      test_fault();
      test_wrap();
`ifdef IFU_MISALIGN_CHK_EN
      test_misalign();
`endif
      do_reset(1'b1, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_ifu_fetch
